// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants for the oversampling UART receiver: FSM state
//            encoding, default clock / line rates and the divisor helper.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Board defaults: 100 MHz system clock, 9600 bit/s line
    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    // Receiver FSM state encoding
    localparam int               STATE_W      = 3;
    localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd1;
    localparam logic [STATE_W-1:0] ST_START     = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA      = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP      = 3'd4;

    // Clocks per sample tick, truncated toward zero
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Free-running divide-by-DIV counter producing a one-cycle sample
//            tick at count DIV-1. A synchronous clear lets the receiver align
//            tick phase to the falling edge of each start bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Divider counter: wraps at DIV-1, forced to zero while clear is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == CNT_MAX)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : 8N1 LSB-first oversampling UART receiver with start-bit glitch
//            rejection, 3-sample majority vote, framing-error detection and
//            a valid/ack holding register with overrun indication.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK_100MHz,
    input  logic       RST,
    input  logic       Rx,
    input  logic       RxAck,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxFrameErr,
    output logic       RxOverrun,
    output logic       RxBusy
);

    // Clocks per sample tick and the three mid-bit sample positions
    localparam int                DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int                SCNT_W = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] SAMP_A = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SAMP_B = SCNT_W'(OVERSAMPLE / 2);
    localparam logic [SCNT_W-1:0] SAMP_C = SCNT_W'(OVERSAMPLE / 2 + 1);

    generate
        if (!((OVERSAMPLE == 8) || (OVERSAMPLE == 16)) || (DIV < 2)) begin : g_param_check
            $error("uart_rx_core: OVERSAMPLE must be 8 or 16 and the derived divisor at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                r_sync1;
    logic                r_rx_s;
    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_state_next;
    logic                w_tick;
    logic [SCNT_W-1:0]   r_scnt;
    logic                r_samp_a;
    logic                r_samp_b;
    logic                w_vote;
    logic                w_decide;
    logic [2:0]          r_bidx;
    logic [7:0]          r_shreg;
    logic [7:0]          r_rx_data;
    logic                r_rx_valid;
    logic                r_frame_err;
    logic                r_overrun;

    // FSM-decoded controls
    logic                w_busy;
    logic                w_cnt_clr;
    logic                w_bit_start;
    logic                w_bit_shift;
    logic                w_frame_ok;
    logic                w_frame_bad;

    // ------------------------------------------------------------------------
    // Input synchronizer; flops idle high so reset does not look like a start
    // ------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous serial pin
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= Rx;
            r_rx_s  <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Sample tick generator, cleared while idle so each frame starts in phase
    // ------------------------------------------------------------------------
    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (CLK_100MHz),
        .rst  (RST),
        .clr  (w_cnt_clr),
        .tick (w_tick)
    );

    // ------------------------------------------------------------------------
    // Sample counter and majority voter
    // ------------------------------------------------------------------------
    // Count ticks within the current bit; wraps naturally every OVERSAMPLE ticks
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            r_scnt <= '0;
        end else if (w_cnt_clr) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            r_scnt <= r_scnt + 1'b1;
        end
    end

    // Capture the first two of the three mid-bit samples
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else if (w_tick) begin
            if (r_scnt == SAMP_A) r_samp_a <= r_rx_s;
            if (r_scnt == SAMP_B) r_samp_b <= r_rx_s;
        end
    end

    // The third sample is the live synchronized value on the decision tick
    assign w_vote   = (r_samp_a & r_samp_b) | (r_samp_a & r_rx_s) | (r_samp_b & r_rx_s);
    assign w_decide = w_tick && (r_scnt == SAMP_C);

    // ------------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_IDLE: if (w_tick && r_rx_s)                   w_state_next = ST_IDLE;
            ST_IDLE:      if (!r_rx_s)                            w_state_next = ST_START;
            ST_START:     if (w_decide)                           w_state_next = w_vote ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_decide && (r_bidx == 3'd7))       w_state_next = ST_STOP;
            ST_STOP:      if (w_decide)                           w_state_next = w_vote ? ST_IDLE : ST_WAIT_IDLE;
            default:                                              w_state_next = ST_WAIT_IDLE;
        endcase
    end

    // Output decode: busy flag and per-state datapath enables
    always_comb begin
        w_busy      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_bit_start = 1'b0;
        w_bit_shift = 1'b0;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
            end
            ST_START: begin
                w_busy      = 1'b1;
                w_bit_start = w_decide && !w_vote;
            end
            ST_DATA: begin
                w_busy      = 1'b1;
                w_bit_shift = w_decide;
            end
            ST_STOP: begin
                w_busy      = 1'b1;
                w_frame_ok  = w_decide && w_vote;
                w_frame_bad = w_decide && !w_vote;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Data path
    // ------------------------------------------------------------------------
    // Bit index: reset by an accepted start bit, saturates at 7
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            r_bidx <= 3'd0;
        end else if (w_bit_start) begin
            r_bidx <= 3'd0;
        end else if (w_bit_shift && (r_bidx != 3'd7)) begin
            r_bidx <= r_bidx + 3'd1;
        end
    end

    // LSB-first shift register: each voted bit enters at the top
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            r_shreg <= 8'h00;
        end else if (w_bit_shift) begin
            r_shreg <= {w_vote, r_shreg[7:1]};
        end
    end

    // Holding register with ack handshake; a completing byte beats a same-cycle ack
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= w_frame_ok && r_rx_valid && !RxAck;
            if (w_frame_ok) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (RxAck) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign RxData     = r_rx_data;
    assign RxValid    = r_rx_valid;
    assign RxFrameErr = r_frame_err;
    assign RxOverrun  = r_overrun;
    assign RxBusy     = w_busy;

endmodule
`default_nettype wire
